// File: rtl/count_seg_display_if.sv
// Bundles the count input with the BCD result and display pin signals.
// The master drives the count; the slave is the display converter itself.
interface count_seg_display_if;
   logic [7:0]  value;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   modport master (output value, input bcd, bcd_valid, seg, dp, an);
   modport slave  (input value, output bcd, bcd_valid, seg, dp, an);
endinterface

// File: rtl/count_seg_display.sv
// Converts an 8-bit count to three BCD digits with a sequential double-dabble, then
// scans them onto a multiplexed seven-segment display with optional leading-zero blanking.
module count_seg_display #(
   parameter int SCAN_DIV   = 50000,
   parameter bit BLANK_LEAD = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   count_seg_display_if.slave  io_disp
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic OFF_LVL = ACTIVE_LOW;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t       r_state, w_nextState;
   logic [7:0]   r_valueLat;
   logic [19:0]  r_shreg;
   logic [2:0]   r_i;
   logic [11:0]  r_bcd;
   logic         r_bcdValid;
   logic         w_load, w_shift, w_done;
   logic [19:0]  w_adj;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic             w_wrap;
   logic [3:0]       w_digit;
   logic             w_blank;
   logic [6:0]       w_segHigh;
   logic [3:0]       w_anHigh;
   logic [6:0]       r_seg;
   logic [3:0]       r_an;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b0000000;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // A new conversion starts only from IDLE, so changes during SHIFT/DONE are picked up afterwards.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (io_disp.value != r_valueLat) w_nextState = SHIFT;
         SHIFT:   if (r_i == 3'd7) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_load  = (r_state == IDLE) && (io_disp.value != r_valueLat);
      w_shift = (r_state == SHIFT);
      w_done  = (r_state == DONE);
   end

   always_comb begin
      w_adj = r_shreg;
      for (int k = 0; k < 3; k++) begin
         if (r_shreg[8+4*k +: 4] >= 4'd5) w_adj[8+4*k +: 4] = r_shreg[8+4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valueLat <= 8'd0;
         r_shreg    <= 20'd0;
         r_i        <= 3'd0;
         r_bcd      <= 12'd0;
         r_bcdValid <= 1'b0;
      end else begin
         r_bcdValid <= 1'b0;
         if (w_load) begin
            r_valueLat <= io_disp.value;
            r_shreg    <= {12'd0, io_disp.value};
            r_i        <= 3'd0;
         end
         if (w_shift) begin
            r_shreg <= {w_adj[18:0], 1'b0};
            r_i     <= r_i + 3'd1;
         end
         if (w_done) begin
            r_bcd      <= r_shreg[19:8];
            r_bcdValid <= 1'b1;
         end
      end
   end

   assign w_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Display reads only the registered bcd so an in-flight conversion never shows.
   always_comb begin
      w_digit  = r_bcd[3:0];
      w_blank  = 1'b0;
      w_anHigh = 4'b0001;
      case (r_idx)
         2'd1: begin
            w_digit  = r_bcd[7:4];
            w_blank  = BLANK_LEAD && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            w_anHigh = 4'b0010;
         end
         2'd2: begin
            w_digit  = r_bcd[11:8];
            w_blank  = BLANK_LEAD && (r_bcd[11:8] == 4'd0);
            w_anHigh = 4'b0100;
         end
         default: ;
      endcase
      w_segHigh = decode(w_digit);
      if (w_blank) begin
         w_anHigh  = 4'b0000;
         w_segHigh = 7'b0000000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= {7{OFF_LVL}};
         r_an  <= {4{OFF_LVL}};
      end else begin
         r_seg <= ACTIVE_LOW ? ~w_segHigh : w_segHigh;
         r_an  <= ACTIVE_LOW ? ~w_anHigh  : w_anHigh;
      end
   end

   assign io_disp.bcd       = r_bcd;
   assign io_disp.bcd_valid = r_bcdValid;
   assign io_disp.seg       = r_seg;
   assign io_disp.dp        = OFF_LVL;
   assign io_disp.an        = r_an;

endmodule
